ram_sdp: RTL and testbench

//  - Simple dual-port synchronous RAM: one write port, one read port, single clock domain.
//  - Write and read proceed independently in the same cycle.
//  - Used as the storage element under the team's RAM verification environment.
//  - Driven by the ram_interface signal bundle.

---
 rtl/ram_sdp_pkg.sv | 17 +
 rtl/ram_sdp_if.sv | 43 ++++
 rtl/ram_sdp_array.sv | 42 ++++
 rtl/ram_sdp.sv | 81 ++++++++
 tb/tb_ram_sdp.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/ram_sdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp_pkg
//  Description : Shared widths and word/address types for the simple
//                dual-port RAM slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_sdp_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : ram_sdp_pkg
`default_nettype wire

// File: rtl/ram_sdp_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp_if
//  Description : Signal bundle for the simple dual-port RAM: one write port,
//                one read port, registered read data back to the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_sdp_if
    import ram_sdp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_din;
    logic                  re;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_dout;

    // Requester side: issues writes and reads, receives read data.
    modport master (
        output we,
        output wr_addr,
        output wr_din,
        output re,
        output rd_addr,
        input  rd_dout
    );

    // RAM side.
    modport slave (
        input  we,
        input  wr_addr,
        input  wr_din,
        input  re,
        input  rd_addr,
        output rd_dout
    );

endinterface : ram_sdp_if
`default_nettype wire

// File: rtl/ram_sdp_array.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp_array
//  Description : Storage array with synchronous clear, one write port and a
//                combinational read tap. Clear has priority over write.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp_array
    import ram_sdp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  wire logic                  clk,
    input  wire logic                  i_clr,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_din,
    input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Clear every word, otherwise commit an enabled write.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_din;
        end
    end

    // Read tap returns the word as stored before this edge's write.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : ram_sdp_array
`default_nettype wire

// File: rtl/ram_sdp.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp
//  Description : Simple dual-port synchronous RAM, single clock. One write
//                port and one read port operate independently each cycle;
//                read data is registered (1-clock latency) and held while
//                re is low. rst is synchronous, active-low, and clears both
//                the read register and every memory word.
//                Same-address write+read collision is read-first by default.
//                Define RAM_BYPASS_EN for write-first forwarding instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp
    import ram_sdp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ram_sdp_if.slave   bus
);

    logic                  w_rst_cycle;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic [DATA_WIDTH-1:0] w_rd_next;
    logic [DATA_WIDTH-1:0] r_rd_dout;

    // Enables use ==1'b1 so an unknown we/re never counts as an access;
    // a reset cycle suppresses both ports.
    assign w_rst_cycle = (rst == 1'b0);
    assign w_wr_en     = (rst == 1'b1) && (bus.we == 1'b1);
    assign w_rd_en     = (rst == 1'b1) && (bus.re == 1'b1);

    ram_sdp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk       (clk),
        .i_clr     (w_rst_cycle),
        .i_we      (w_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_din  (bus.wr_din),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_mem_rd)
    );

`ifdef RAM_BYPASS_EN
    logic w_collide;

    assign w_collide = w_wr_en && w_rd_en && (bus.wr_addr == bus.rd_addr);

    // Forward the incoming write word on a same-address collision.
    always_comb begin
        w_rd_next = w_mem_rd;
        if (w_collide) begin
            w_rd_next = bus.wr_din;
        end
    end
`else
    // Read-first: the tap already shows the pre-write word.
    always_comb begin
        w_rd_next = w_mem_rd;
    end
`endif

    // Read data register: cleared on reset, loaded on read, held otherwise.
    always_ff @(posedge clk) begin
        if (w_rst_cycle) begin
            r_rd_dout <= '0;
        end else if (w_rd_en) begin
            r_rd_dout <= w_rd_next;
        end
    end

    assign bus.rd_dout = r_rd_dout;

endmodule : ram_sdp
`default_nettype wire

// File: tb/tb_ram_sdp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sdp
//  Description : Self-checking bench for ram_sdp. The driver pushes the
//                expected rd_dout for each observed cycle into a queue; a
//                monitor pops and compares just after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sdp;
    import ram_sdp_pkg::*;

    logic clk;
    logic rst;
    logic chk;
    int   n_tests;
    int   n_fail;
    data_t exp_q[$];
    string name_q[$];

    ram_sdp_if #(.DATA_WIDTH(DATA_WIDTH_DEF), .ADDR_WIDTH(ADDR_WIDTH_DEF)) bus ();

    ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH_DEF),
        .ADDR_WIDTH (ADDR_WIDTH_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus, applied on the falling edge. When c is set, the
    // expected rd_dout after the next rising edge is queued.
    task automatic drive(input logic r, input logic w, input addr_t wa,
                         input data_t wd, input logic rd, input addr_t ra,
                         input logic c, input data_t e, input string nm);
        @(negedge clk);
        rst          = r;
        bus.we       = w;
        bus.wr_addr  = wa;
        bus.wr_din   = wd;
        bus.re       = rd;
        bus.rd_addr  = ra;
        chk          = c;
        if (c) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    // Monitor: compare rd_dout shortly after every edge flagged for checking.
    initial begin
        logic  s;
        data_t e;
        string nm;
        forever begin
            @(posedge clk);
            s = chk;
            #1;
            if (s) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: rd_dout=%0h, no expected value", bus.rd_dout);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (bus.rd_dout !== e) begin
                        n_fail++;
                        $display("FAIL %s: rd_dout=%0h expected=%0h", nm, bus.rd_dout, e);
                    end
                end
            end
        end
    end

    initial begin
        data_t col_exp;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; chk = 1'b0;
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_din = '0;
        bus.re = 1'b0; bus.rd_addr = '0;

`ifdef RAM_BYPASS_EN
        col_exp = 8'h22;
`else
        col_exp = 8'h11;
`endif

        // Reset sequence: 1 idle cycle, 2 reset cycles, release.
        drive(1, 0, 0, 0, 0, 0, 0, 0, "idle");
        drive(0, 0, 0, 0, 0, 0, 0, 0, "rst1");
        drive(0, 0, 0, 0, 0, 0, 1, 8'h00, "reset_dout");
        drive(1, 0, 0, 0, 1, 5, 1, 8'h00, "read5_after_reset");

        // Write then read.
        drive(1, 1, 3, 8'hA5, 0, 0, 0, 0, "wr3");
        drive(1, 0, 0, 0, 1, 3, 1, 8'hA5, "read3");

        // Hold: re low, writes elsewhere, rd_dout unchanged.
        drive(1, 1, 4, 8'h44, 0, 3, 1, 8'hA5, "hold1");
        drive(1, 1, 6, 8'h66, 0, 4, 1, 8'hA5, "hold2");
        drive(1, 1, 8, 8'h88, 0, 6, 1, 8'hA5, "hold3");

        // Sweep: write i*3 everywhere, then read back (15 -> 0 back to back).
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, addr_t'(i), data_t'(i * 3), 0, 0, 0, 0, "sweep_wr");
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 1, addr_t'(i), 1, data_t'(i * 3), $sformatf("sweep_rd%0d", i));
        end
        drive(1, 0, 0, 0, 1, 0, 1, 8'h00, "sweep_rd0_after15");

        // Collision at address 7.
        drive(1, 1, 7, 8'h11, 0, 0, 0, 0, "col_pre");
        drive(1, 1, 7, 8'h22, 1, 7, 1, col_exp, "collision");
        drive(1, 0, 0, 0, 1, 7, 1, 8'h22, "after_collision");

        // Independent write and read to different addresses.
        drive(1, 1, 2, 8'h5A, 1, 9, 1, 8'h1B, "indep_rd9");
        drive(1, 0, 0, 0, 1, 2, 1, 8'h5A, "indep_rd2");

        // Mid-op reset: write and read suppressed, memory cleared.
        drive(0, 1, 2, 8'hFF, 1, 7, 1, 8'h00, "midrst_dout");
        drive(1, 0, 0, 0, 1, 2, 1, 8'h00, "midrst_rd2");
        drive(1, 0, 0, 0, 1, 7, 1, 8'h00, "midrst_rd7");

        drive(1, 0, 0, 0, 0, 0, 0, 0, "drain");
        drive(1, 0, 0, 0, 0, 0, 0, 0, "drain");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: pending=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_sdp
`default_nettype wire
